alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (power of two, 8..64).
REQ-002 SHALL have derived localparam SHW = $clog2(WIDTH), shift-amount and iteration-counter width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk and reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operation request.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 A, B  input  WIDTH each  operands.
REQ-009 ALUControl_in  input  4  opcode.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 ALU_result  output  WIDTH  result.
REQ-013 zero  output  1  ALU_result == 0.
REQ-014 busy  output  1  iterative operation in progress.

Function
REQ-015 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1001 SRA, 1010 MUL (low WIDTH bits), 1011 DIVU, 1100 REMU; any other code passes A.
REQ-016 Shifts SHALL use B[SHW-1:0] only; ADD/SUB/MUL wrap modulo 2^WIDTH; SLT/SLTU return 1 or 0 zero-extended.
REQ-017 zero SHALL be computed from the registered result for every opcode, not only SUB.
REQ-018 FSM states SHALL be IDLE, BUSY, DONE.
REQ-019 Transfer occurs when in_valid && in_ready; A, B, opcode SHALL be captured at that edge and input changes afterwards ignored.
REQ-020 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready is 1, else 0.
REQ-021 Single-cycle opcodes: IDLE/DONE -> DONE, out_valid asserted the cycle after acceptance (latency 1).
REQ-022 MUL/DIVU/REMU: -> BUSY for exactly WIDTH cycles (shift-add multiply, restoring divide, one bit per cycle), then DONE; latency WIDTH+1.
REQ-023 Divide by zero SHALL skip BUSY with latency 1: DIVU returns all ones, REMU returns A.
REQ-024 In DONE, ALU_result/zero SHALL hold stable while out_valid && !out_ready.
REQ-025 DONE with out_ready and no new transfer -> IDLE, out_valid deasserted next cycle.
REQ-026 DONE with out_ready and simultaneous new transfer SHALL start the new operation with no bubble.
REQ-027 busy SHALL equal (state == BUSY); in_valid in BUSY is not accepted.

Reset
REQ-028 Reset SHALL force state IDLE, out_valid 0, ALU_result 0, zero 1, busy 0, iteration counter and partial registers 0.
REQ-029 Reset asserted mid-operation SHALL abort it with no result ever presented; in_ready is 1 the first cycle after deassertion.

Structure
REQ-030 Package alu_pkg SHALL hold the opcode constants and the state enum type.
REQ-031 Iterative datapath SHALL be one sub-module alu_muldiv (start, op, operands, counter-driven done, result); single-cycle ops stay in alu_seq.

Verification
REQ-032 ADD A=0x7FFFFFFF, B=1, out_ready=1 -> out_valid one cycle later, result 0x80000000, zero 0; SUB A=B=5 -> 0, zero 1.
REQ-033 SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same operands -> 0; SRA A=0x80000000, B=0x21 -> 0xC0000000.
REQ-034 MUL 0x0001_0000 * 0x0001_0000 -> 0 after 33 cycles, zero 1, busy high 32 cycles; DIVU 100/7 -> 14, REMU -> 2.
REQ-035 DIVU 9/0 -> 0xFFFFFFFF, REMU 9/0 -> 9, each with latency 1.
REQ-036 out_ready held 0 for 5 cycles after DONE -> result stable, in_ready 0; then out_ready 1 with in_valid 1 -> back-to-back accept with no bubble.
REQ-037 Reset pulsed at BUSY cycle 10 of a DIVU -> IDLE, out_valid never asserted for it, ALU_result 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and opcode helpers for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Opcodes served by the one-bit-per-cycle datapath
    function automatic logic is_iter(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus of the sequential ALU; master issues operations, slave is the ALU.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUControl_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_result;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, A, B, ALUControl_in, out_ready,
        input  in_ready, out_valid, ALU_result, zero, busy
    );

    modport slave (
        input  in_valid, A, B, ALUControl_in, out_ready,
        output in_ready, out_valid, ALU_result, zero, busy
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle for WIDTH cycles.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_c,
    output logic [WIDTH-1:0] result_c
);

    localparam int unsigned SHW = $clog2(WIDTH);

    // p: accumulator / remainder, x: multiplicand / quotient, y: multiplier / divisor
    logic             active;
    logic [SHW-1:0]   cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] p_q, x_q, y_q;
    logic [WIDTH-1:0] p_d, x_d, y_d;
    logic [WIDTH:0]   shifted, diff;

    always_comb begin
        p_d     = p_q;
        x_d     = x_q;
        y_d     = y_q;
        shifted = '0;
        diff    = '0;
        if (op_q == OP_MUL) begin
            p_d = y_q[0] ? (p_q + x_q) : p_q;
            x_d = x_q << 1;
            y_d = y_q >> 1;
        end else begin
            // Top bit of diff is the borrow: set when the divisor does not fit
            shifted = {p_q, x_q[WIDTH-1]};
            diff    = shifted - {1'b0, y_q};
            if (!diff[WIDTH]) begin
                p_d = diff[WIDTH-1:0];
                x_d = {x_q[WIDTH-2:0], 1'b1};
            end else begin
                p_d = shifted[WIDTH-1:0];
                x_d = {x_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign done_c   = active && (cnt == SHW'(WIDTH - 1));
    assign result_c = (op_q == OP_DIVU) ? x_d : p_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
            op_q   <= '0;
            p_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            op_q   <= op;
            p_q    <= '0;
            x_q    <= a;
            y_q    <= b;
        end else if (active) begin
            p_q <= p_d;
            x_q <= x_d;
            y_q <= y_d;
            cnt <= cnt + SHW'(1);
            if (done_c) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake: single-cycle ops complete in one cycle,
// MUL/DIVU/REMU run WIDTH cycles in alu_muldiv.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_e           state;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_c;
    logic             accept_c;
    logic             div_zero_c;
    logic             iter_c;
    logic             md_start_c;
    logic             md_done_c;
    logic [WIDTH-1:0] md_result_c;

    assign bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.zero     = (bus.ALU_result == '0);

    assign shamt      = bus.B[SHW-1:0];
    assign accept_c   = bus.in_valid && bus.in_ready;
    assign div_zero_c = is_div(bus.ALUControl_in) && (bus.B == '0);
    assign iter_c     = is_iter(bus.ALUControl_in) && !div_zero_c;
    assign md_start_c = accept_c && iter_c;

    // Single-cycle results, including the divide-by-zero shortcuts
    always_comb begin
        alu_c = bus.A;
        case (bus.ALUControl_in)
            OP_AND:  alu_c = bus.A & bus.B;
            OP_OR:   alu_c = bus.A | bus.B;
            OP_ADD:  alu_c = bus.A + bus.B;
            OP_XOR:  alu_c = bus.A ^ bus.B;
            OP_SLL:  alu_c = bus.A << shamt;
            OP_SRL:  alu_c = bus.A >> shamt;
            OP_SUB:  alu_c = bus.A - bus.B;
            OP_SLT:  alu_c = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: alu_c = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            OP_SRA:  alu_c = WIDTH'($signed(bus.A) >>> shamt);
            OP_DIVU: alu_c = '1;
            default: alu_c = bus.A;
        endcase
    end

    alu_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start    (md_start_c),
        .op       (bus.ALUControl_in),
        .a        (bus.A),
        .b        (bus.B),
        .done_c   (md_done_c),
        .result_c (md_result_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            bus.out_valid  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.ALU_result <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept_c) begin
                        if (iter_c) begin
                            state         <= BUSY;
                            bus.busy      <= 1'b1;
                            bus.out_valid <= 1'b0;
                        end else begin
                            state          <= DONE;
                            bus.out_valid  <= 1'b1;
                            bus.ALU_result <= alu_c;
                        end
                    end else if ((state == DONE) && bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (md_done_c) begin
                        state          <= DONE;
                        bus.busy       <= 1'b0;
                        bus.out_valid  <= 1'b1;
                        bus.ALU_result <= md_result_c;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: per-cycle comparison against a transaction-level model
// plus directed vectors with literal expected results and latencies.
module tb_alu_seq;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   checking = 1'b0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Arithmetic reference for every opcode
    function automatic logic [W-1:0] golden(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        sa = a;
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd4:    return a << b[4:0];
            4'd5:    return a >> b[4:0];
            4'd6:    return a - b;
            4'd7:    return (sa < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:    return (a < b) ? 32'd1 : 32'd0;
            4'd9:    return W'(sa >>> b[4:0]);
            4'd10:   return W'(a * b);
            4'd11:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd12:   return (b == 0) ? a : a % b;
            default: return a;
        endcase
    endfunction

    function automatic bit is_slow(input logic [3:0] op, input logic [W-1:0] b);
        return (op == 4'd10) || (((op == 4'd11) || (op == 4'd12)) && (b != 0));
    endfunction

    // Transaction model: a result is owed after 1 cycle, or after W busy cycles for slow ops
    logic         m_valid;
    logic [W-1:0] m_res;
    logic [W-1:0] m_pend;
    int           m_left;

    function automatic bit m_ready();
        return (m_left == 0) && (!m_valid || bus.out_ready);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_res   <= '0;
            m_pend  <= '0;
            m_left  <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid <= 1'b1;
                m_res   <= m_pend;
            end
        end else if (bus.in_valid && m_ready()) begin
            if (is_slow(bus.ALUControl_in, bus.B)) begin
                m_left  <= W;
                m_pend  <= golden(bus.ALUControl_in, bus.A, bus.B);
                m_valid <= 1'b0;
            end else begin
                m_valid <= 1'b1;
                m_res   <= golden(bus.ALUControl_in, bus.A, bus.B);
            end
        end else if (m_valid && bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("cyc_out_valid", 64'(bus.out_valid), 64'(m_valid));
            check("cyc_busy", 64'(bus.busy), 64'(m_left != 0));
            check("cyc_in_ready", 64'(bus.in_ready), 64'(m_ready()));
            check("cyc_result", 64'(bus.ALU_result), 64'(m_res));
            check("cyc_zero", 64'(bus.zero), 64'(m_res == 0));
        end
    end

    // Issue one operation, scramble inputs after acceptance, measure latency and busy cycles
    task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat,
                          input int exp_busy);
        int lat;
        int nbusy;
        bit seen;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.ALUControl_in = op;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
        bus.ALUControl_in = 4'($urandom);
        lat = 1;
        nbusy = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.out_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        if (!seen) lat = -1;
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_busy"}, 64'(nbusy), 64'(exp_busy));
        check({name, "_res"}, 64'(bus.ALU_result), 64'(exp));
        check({name, "_zero"}, 64'(bus.zero), 64'(exp == 0));
    endtask

    initial begin
        bit saw_valid;
        int nbusy;
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.ALUControl_in = 4'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checking = 1'b1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.ALU_result), 64'd0);
        check("rst_zero", 64'(bus.zero), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        run_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0);
        run_op("sub_eq", 4'd6, 32'd5, 32'd5, 32'h0, 1, 0);
        run_op("slt", 4'd7, 32'hFFFF_FFFF, 32'h1, 32'h1, 1, 0);
        run_op("sltu", 4'd8, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);
        run_op("sra", 4'd9, 32'h8000_0000, 32'h21, 32'hC000_0000, 1, 0);
        run_op("and", 4'd0, 32'hF0F0_1234, 32'hFF00_FF0F, 32'hF000_1204, 1, 0);
        run_op("or", 4'd1, 32'hF000_0001, 32'h0F00_0010, 32'hFF00_0011, 1, 0);
        run_op("xor", 4'd3, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1, 0);
        run_op("sll", 4'd4, 32'h1, 32'h24, 32'h10, 1, 0);
        run_op("srl", 4'd5, 32'h8000_0000, 32'h1F, 32'h1, 1, 0);
        run_op("pass", 4'd15, 32'hDEAD_BEEF, 32'h1, 32'hDEAD_BEEF, 1, 0);
        run_op("mul_wrap", 4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0, 33, 32);
        run_op("mul", 4'd10, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 33, 32);
        run_op("divu", 4'd11, 32'd100, 32'd7, 32'd14, 33, 32);
        run_op("remu", 4'd12, 32'd100, 32'd7, 32'd2, 33, 32);
        run_op("divu_big", 4'd11, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33, 32);
        run_op("remu_big", 4'd12, 32'd5, 32'h8000_0000, 32'd5, 33, 32);
        run_op("divu_z", 4'd11, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("remu_z", 4'd12, 32'd9, 32'd0, 32'd9, 1, 0);

        // Backpressure: result must hold while out_ready is low, then chain without a bubble
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.A = 32'd3;
        bus.B = 32'd4;
        bus.ALUControl_in = 4'd2;
        @(posedge clk); #1;
        bus.A = 32'd20;
        bus.B = 32'd3;
        bus.ALUControl_in = 4'd6;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_res", 64'(bus.ALU_result), 64'd7);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
        check("b2b_old_res", 64'(bus.ALU_result), 64'd7);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid", 64'(bus.out_valid), 64'd1);
        check("b2b_res", 64'(bus.ALU_result), 64'd17);

        // Reset in the middle of a divide aborts it silently
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.A = 32'd100;
        bus.B = 32'd7;
        bus.ALUControl_in = 4'd11;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 40 && nbusy < 10; i++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
        end
        check("abort_reached_busy10", 64'(nbusy), 64'd10);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        saw_valid = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) saw_valid = 1'b1;
            check("abort_res", 64'(bus.ALU_result), 64'd0);
            check("abort_busy", 64'(bus.busy), 64'd0);
            @(negedge clk);
        end
        check("abort_no_valid", 64'(saw_valid), 64'd0);

        run_op("post_abort_add", 4'd2, 32'd1, 32'd2, 32'd3, 1, 0);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
